// File: rtl/mem_stage_ctrl.sv
// WISC memory stage: drives a multi-cycle data memory over a req/done
// handshake, stalls upstream while busy, and registers writeback.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidIn,
  input  logic [15:0] AluRes,
  input  logic [15:0] RtIn,
  input  logic        RegWriteIn,
  input  logic        DMemWriteIn,
  input  logic        DMemEnIn,
  input  logic        MemToRegIn,
  input  logic        DMemDumpIn,
  input  logic [2:0]  RdAddrIn,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWrData,
  output logic        MemRd,
  output logic        MemWr,
  output logic        MemDump,
  input  logic [15:0] MemRdData,
  input  logic        MemDone,
  output logic        Stall,
  output logic        ValidOut,
  output logic [15:0] WbData,
  output logic        RegWriteOut,
  output logic [2:0]  RdAddrOut,
  output logic        Err,
  output logic        Halt
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, HALTED
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             m2r_q;
  logic             rw_q;
  logic [2:0]       rd_q;

  logic in_idle;
  logic dump;
  logic accept;
  logic misal;
  logic nonmem;
  logic timeout;

  assign in_idle = (state == IDLE);
  assign dump    = in_idle & ValidIn & DMemDumpIn;
  assign accept  = in_idle & ValidIn & DMemEnIn
                 & ~AluRes[0] & ~DMemDumpIn;
  assign misal   = in_idle & ValidIn & DMemEnIn
                 & AluRes[0] & ~DMemDumpIn;
  assign nonmem  = in_idle & ValidIn & ~DMemEnIn
                 & ~DMemDumpIn;
  assign timeout = (state == WAIT) & ~MemDone
                 & (cnt == CNT_W'(TIMEOUT - 1));

  // Released in the completion/timeout cycle so upstream advances on that edge
  assign Stall = accept | dump
               | (state == ISSUE)
               | ((state == WAIT) & ~MemDone & ~timeout)
               | (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      m2r_q       <= 1'b0;
      rw_q        <= 1'b0;
      rd_q        <= 3'd0;
      MemAddr     <= 16'd0;
      MemWrData   <= 16'd0;
      MemRd       <= 1'b0;
      MemWr       <= 1'b0;
      MemDump     <= 1'b0;
      ValidOut    <= 1'b0;
      WbData      <= 16'd0;
      RegWriteOut <= 1'b0;
      RdAddrOut   <= 3'd0;
      Err         <= 1'b0;
      Halt        <= 1'b0;
    end else begin
      MemRd   <= 1'b0;
      MemWr   <= 1'b0;
      MemDump <= 1'b0;
      case (state)
        IDLE: begin
          ValidOut    <= 1'b0;
          RegWriteOut <= 1'b0;
          if (dump) begin
            MemDump <= 1'b1;
            Halt    <= 1'b1;
            state   <= HALTED;
          end else if (accept) begin
            // MemAddr/MemWrData double as the request latch
            MemAddr   <= AluRes;
            MemWrData <= RtIn;
            m2r_q     <= MemToRegIn;
            rw_q      <= RegWriteIn;
            rd_q      <= RdAddrIn;
            MemRd     <= ~DMemWriteIn;
            MemWr     <= DMemWriteIn;
            state     <= ISSUE;
          end else if (misal) begin
            ValidOut  <= 1'b1;
            RdAddrOut <= RdAddrIn;
            Err       <= 1'b1;
          end else if (nonmem) begin
            ValidOut    <= 1'b1;
            WbData      <= AluRes;
            RegWriteOut <= RegWriteIn;
            RdAddrOut   <= RdAddrIn;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (MemDone) begin
            ValidOut    <= 1'b1;
            RdAddrOut   <= rd_q;
            RegWriteOut <= rw_q;
            WbData      <= m2r_q ? MemRdData : MemAddr;
            state       <= IDLE;
          end else if (timeout) begin
            Err         <= 1'b1;
            ValidOut    <= 1'b1;
            RegWriteOut <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HALTED: begin
          ValidOut    <= 1'b0;
          RegWriteOut <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl with a latency-programmable
// memory model; TIMEOUT shrunk to 4 to reach the abort path quickly.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ValidIn = 1'b0;
  logic [15:0] AluRes = 16'd0;
  logic [15:0] RtIn = 16'd0;
  logic        RegWriteIn = 1'b0;
  logic        DMemWriteIn = 1'b0;
  logic        DMemEnIn = 1'b0;
  logic        MemToRegIn = 1'b0;
  logic        DMemDumpIn = 1'b0;
  logic [2:0]  RdAddrIn = 3'd0;
  logic [15:0] MemAddr;
  logic [15:0] MemWrData;
  logic        MemRd;
  logic        MemWr;
  logic        MemDump;
  logic [15:0] mem_rdata = 16'd0;
  logic        MemDone = 1'b0;
  logic        Stall;
  logic        ValidOut;
  logic [15:0] WbData;
  logic        RegWriteOut;
  logic [2:0]  RdAddrOut;
  logic        Err;
  logic        Halt;

  mem_stage_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .ValidIn(ValidIn), .AluRes(AluRes), .RtIn(RtIn),
    .RegWriteIn(RegWriteIn), .DMemWriteIn(DMemWriteIn),
    .DMemEnIn(DMemEnIn), .MemToRegIn(MemToRegIn),
    .DMemDumpIn(DMemDumpIn), .RdAddrIn(RdAddrIn),
    .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemRd(MemRd), .MemWr(MemWr), .MemDump(MemDump),
    .MemRdData(mem_rdata), .MemDone(MemDone),
    .Stall(Stall), .ValidOut(ValidOut), .WbData(WbData),
    .RegWriteOut(RegWriteOut), .RdAddrOut(RdAddrOut),
    .Err(Err), .Halt(Halt)
  );

  always #5 clk = ~clk;

  // lat = WAIT cycles up to and including MemDone; 0 = never answer
  int   mem_lat = 0;
  logic poke = 1'b0;
  logic busy = 1'b0;
  int   w = 0;
  always @(posedge clk) begin
    logic hit;
    #2;
    hit = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else if (MemRd || MemWr) begin
      busy = 1'b1;
      w = 0;
    end else if (busy) begin
      w++;
      if (mem_lat != 0 && w == mem_lat) begin
        hit = 1'b1;
        busy = 1'b0;
      end
    end
    MemDone = hit | poke;
  end

  typedef struct {
    logic [15:0] data;
    logic        rw;
    logic [2:0]  rd;
    bit          full;
  } wb_t;

  wb_t q[$];
  int tests = 0;
  int fails = 0;
  int n_stall = 0, n_rd = 0, n_wr = 0;
  int n_dump = 0, n_valid = 0;
  logic [15:0] last_addr = 16'd0;
  logic [15:0] last_wdata = 16'd0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    wb_t e;
    @(negedge clk);
    if (Stall) n_stall++;
    if (MemRd) begin
      n_rd++;
      last_addr = MemAddr;
    end
    if (MemWr) begin
      n_wr++;
      last_addr = MemAddr;
      last_wdata = MemWrData;
    end
    if (MemDump) n_dump++;
    if (ValidOut) begin
      n_valid++;
      if (q.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("wb_rw", {31'd0, RegWriteOut}, {31'd0, e.rw});
        if (e.full) begin
          check("wb_data", {16'd0, WbData}, {16'd0, e.data});
          check("wb_rd", {29'd0, RdAddrOut}, {29'd0, e.rd});
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ValidIn = 1'b0;
    DMemEnIn = 1'b0;
    DMemWriteIn = 1'b0;
    MemToRegIn = 1'b0;
    RegWriteIn = 1'b0;
    DMemDumpIn = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    idle_inputs();
    tick();
    step();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_op(input logic en, input logic we,
                       input logic m2r, input logic rw,
                       input logic [15:0] alu, input logic [15:0] rt,
                       input logic [2:0] rd, input int lat,
                       input logic [15:0] rdata, output int stalls);
    int  s0;
    bit  freed;
    wb_t e;
    s0 = n_stall;
    mem_lat = lat;
    step();
    mem_rdata = rdata;
    ValidIn = 1'b1;
    DMemEnIn = en;
    DMemWriteIn = we;
    MemToRegIn = m2r;
    RegWriteIn = rw;
    AluRes = alu;
    RtIn = rt;
    RdAddrIn = rd;
    if (!en) e = '{alu, rw, rd, 1'b1};
    else if (alu[0]) e = '{16'd0, 1'b0, rd, 1'b0};
    else if (lat == 0 || lat > 4) e = '{16'd0, 1'b0, 3'd0, 1'b0};
    else e = '{m2r ? rdata : alu, rw, rd, 1'b1};
    q.push_back(e);
    freed = 1'b0;
    for (int i = 0; i < 40 && !freed; i++) begin
      tick();
      if (!Stall) freed = 1'b1;
    end
    if (!freed) check("stall_bound", 32'd1, 32'd0);
    step();
    idle_inputs();
    tick();
    tick();
    stalls = n_stall - s0;
  endtask

  int st, r0, w0, v0, d0, s0;

  initial begin
    tick();
    check("rst_valid", {31'd0, ValidOut}, 32'd0);
    check("rst_wbdata", {16'd0, WbData}, 32'd0);
    check("rst_err", {31'd0, Err}, 32'd0);
    check("rst_halt", {31'd0, Halt}, 32'd0);
    check("rst_strobes", {29'd0, MemRd, MemWr, MemDump}, 32'd0);
    check("rst_addr", {MemAddr, MemWrData}, 32'd0);
    step();
    rst = 1'b0;
    tick();

    v0 = n_valid;
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0, 3'd5,
          0, 16'h0, st);
    check("alu_stall", st, 0);
    check("alu_valid_cycles", n_valid - v0, 1);

    r0 = n_rd; w0 = n_wr; v0 = n_valid;
    do_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0, 3'd1,
          2, 16'hBEEF, st);
    check("ld_stall", st, 3);
    check("ld_rd_pulse", n_rd - r0, 1);
    check("ld_wr_pulse", n_wr - w0, 0);
    check("ld_addr", {16'd0, last_addr}, 32'h0040);
    check("ld_valid_cycles", n_valid - v0, 1);

    r0 = n_rd; w0 = n_wr;
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hA5A5, 3'd2,
          1, 16'h0, st);
    check("st_stall", st, 2);
    check("st_wr_pulse", n_wr - w0, 1);
    check("st_rd_pulse", n_rd - r0, 0);
    check("st_addr", {16'd0, last_addr}, 32'h0010);
    check("st_wdata", {16'd0, last_wdata}, 32'hA5A5);
    check("st_err", {31'd0, Err}, 32'd0);

    do_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0, 3'd4,
          0, 16'h0, st);
    check("to_stall", st, 5);
    check("to_err", {31'd0, Err}, 32'd1);
    v0 = n_valid;
    poke = 1'b1;
    tick();
    poke = 1'b0;
    tick();
    tick();
    check("to_late_done", n_valid - v0, 0);

    do_reset();
    check("rst2_err", {31'd0, Err}, 32'd0);
    r0 = n_rd; w0 = n_wr;
    do_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h0011, 16'h0, 3'd3,
          1, 16'h0, st);
    check("mis_stall", st, 0);
    check("mis_strobes", (n_rd - r0) + (n_wr - w0), 0);
    check("mis_err", {31'd0, Err}, 32'd1);
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h0, 3'd6,
          0, 16'h0, st);
    check("mis_next_stall", st, 0);
    check("mis_err_sticky", {31'd0, Err}, 32'd1);

    do_reset();
    do_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h0, 3'd2,
          4, 16'hC0DE, st);
    check("edge_stall", st, 5);
    check("edge_err", {31'd0, Err}, 32'd0);

    mem_lat = 0;
    step();
    ValidIn = 1'b1;
    DMemEnIn = 1'b1;
    MemToRegIn = 1'b1;
    RegWriteIn = 1'b1;
    AluRes = 16'h0080;
    RdAddrIn = 3'd2;
    tick();
    tick();
    tick();
    check("mid_addr", {16'd0, MemAddr}, 32'h0080);
    check("mid_stall", {31'd0, Stall}, 32'd1);
    v0 = n_valid;
    do_reset();
    check("mid_rst_outs",
          {ValidOut, RegWriteOut, Err, Halt, MemRd, MemWr, MemDump},
          32'd0);
    check("mid_rst_addr", {MemAddr, MemWrData}, 32'd0);
    check("mid_rst_stall", {31'd0, Stall}, 32'd0);
    poke = 1'b1;
    tick();
    poke = 1'b0;
    tick();
    tick();
    check("mid_late_done", n_valid - v0, 0);
    r0 = n_rd;
    do_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h0100, 16'h0, 3'd7,
          1, 16'h1357, st);
    check("post_rst_stall", st, 2);
    check("post_rst_rd", n_rd - r0, 1);
    check("sb_drain", q.size(), 0);

    d0 = n_dump; r0 = n_rd; w0 = n_wr; v0 = n_valid;
    step();
    ValidIn = 1'b1;
    DMemEnIn = 1'b1;
    DMemDumpIn = 1'b1;
    AluRes = 16'h0002;
    tick();
    check("dump_stall_in", {31'd0, Stall}, 32'd1);
    s0 = n_stall;
    for (int i = 0; i < 6; i++) tick();
    check("dump_pulse", n_dump - d0, 1);
    check("dump_stall_held", n_stall - s0, 6);
    check("dump_halt", {31'd0, Halt}, 32'd1);
    check("dump_no_mem", (n_rd - r0) + (n_wr - w0), 0);
    check("dump_no_valid", n_valid - v0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
